// File: rtl/ysyx_22041412_sram_bw.sv
// ysyx_22041412_sram_bw: 1R1W synchronous SRAM model with byte strobes,
// write-first collision bypass, base-address range checking, 1- or 2-cycle
// read latency and an optional post-reset array clear.
module ysyx_22041412_sram_bw #(
   parameter int                    ADDR_WIDTH   = 64,
   parameter int                    DATA_WIDTH   = 64,
   parameter int                    DATA_DEPTH   = 65536,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(64'h8000_0000),
   parameter int                    RD_LAT       = 1,
   parameter int                    CLEAR_ON_RST = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    ready,
   input  logic                    rd_en,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    rd_err,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_strb,
   output logic                    wr_err
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(DATA_DEPTH);
   // Size of the mapped window in bytes; offsets at or beyond it are errors.
   localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(64'(DATA_DEPTH) * 64'(BYTES));

   typedef enum logic {S_INIT, S_RUN} state_t;

   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      cnt_q, cnt_d;
   logic                  ready_q, ready_d;
   logic                  wr_err_q, wr_err_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_err_q, rd_err_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

   logic [ADDR_WIDTH-1:0] rd_off, wr_off;
   logic [IDX_W-1:0]      rd_idx, wr_idx;
   logic                  rd_in, wr_in;
   logic                  rd_acc, wr_acc;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  s1_vld, s1_err;
   logic [DATA_WIDTH-1:0] s1_data;
   logic                  fin_vld, fin_err;
   logic [DATA_WIDTH-1:0] fin_data;

   // Address translation and range check for both ports.
   always_comb begin
      rd_off = rd_addr - BASE_ADDR;
      wr_off = wr_addr - BASE_ADDR;
      rd_in  = (rd_addr >= BASE_ADDR) && (rd_off < SPAN);
      wr_in  = (wr_addr >= BASE_ADDR) && (wr_off < SPAN);
      rd_idx = IDX_W'(rd_off >> OFF_W);
      wr_idx = IDX_W'(wr_off >> OFF_W);
      // ready_q doubles as the "requests accepted" gate so ready and acceptance never disagree.
      rd_acc = ready_q && rd_en;
      wr_acc = ready_q && wr_en && wr_in;
   end

   // Array read with write-first bypass of same-cycle strobed bytes; out-of-range reads return 0.
   always_comb begin
      rd_word = mem[rd_idx];
      for (int i = 0; i < BYTES; i++) begin
         if (wr_en && wr_in && (wr_idx == rd_idx) && wr_strb[i])
            rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
      if (!rd_in) rd_word = '0;
      s1_vld  = rd_acc;
      s1_err  = rd_acc && !rd_in;
      s1_data = rd_word;
   end

   // Optional extra register stage; the merged word is captured at issue, so later writes don't leak in.
   if (RD_LAT == 2) begin : g_lat2
      logic                  m_vld_q, m_err_q;
      logic [DATA_WIDTH-1:0] m_data_q;
      // Middle read stage, flushed by reset.
      always_ff @(posedge clk) begin
         if (rst) begin
            m_vld_q  <= 1'b0;
            m_err_q  <= 1'b0;
            m_data_q <= '0;
         end else begin
            m_vld_q  <= s1_vld;
            m_err_q  <= s1_err;
            m_data_q <= s1_data;
         end
      end
      assign fin_vld  = m_vld_q;
      assign fin_err  = m_err_q;
      assign fin_data = m_data_q;
   end else begin : g_lat1
      assign fin_vld  = s1_vld;
      assign fin_err  = s1_err;
      assign fin_data = s1_data;
   end

   // Next-state logic: clear sequencer, ready, error pulse and read output hold.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == S_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == IDX_W'(DATA_DEPTH - 1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
         end
      end
      ready_d    = (state_d == S_RUN);
      wr_err_d   = ready_q && wr_en && !wr_in;
      rd_valid_d = fin_vld;
      rd_err_d   = fin_err;
      rd_data_d  = fin_vld ? fin_data : rd_data_q;
   end

   // FSM and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= (CLEAR_ON_RST != 0) ? S_INIT : S_RUN;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         wr_err_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         wr_err_q   <= wr_err_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Array update: zero fill while clearing, strobed byte writes while running.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == S_INIT) begin
            mem[cnt_q] <= '0;
         end else if (wr_acc) begin
            for (int i = 0; i < BYTES; i++) begin
               if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   assign ready    = ready_q;
   assign wr_err   = wr_err_q;
   assign rd_valid = rd_valid_q;
   assign rd_err   = rd_err_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ysyx_22041412_sram_bw.sv
// Directed bench: two instances (RD_LAT=1 and RD_LAT=2) share one stimulus stream.
module tb_ysyx_22041412_sram_bw;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0, wr_en = 1'b0;
   logic [63:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
   logic [7:0]  wr_strb = '0;
   logic        rdy1, rdy2, rv1, rv2, re1, re2, we1, we2;
   logic [63:0] rd1, rd2;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   ysyx_22041412_sram_bw #(.DATA_DEPTH(16), .RD_LAT(1)) u_l1 (
      .clk(clk), .rst(rst), .ready(rdy1), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd1),
      .rd_valid(rv1), .rd_err(re1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_strb(wr_strb), .wr_err(we1));

   ysyx_22041412_sram_bw #(.DATA_DEPTH(16), .RD_LAT(2)) u_l2 (
      .clk(clk), .rst(rst), .ready(rdy2), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd2),
      .rd_valid(rv2), .rd_err(re2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_strb(wr_strb), .wr_err(we2));

   function automatic logic [63:0] pat(input int i);
      return {32'hC0DE_0000 + 32'(i), 32'h1000_0000 + 32'(i * 17)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One write cycle; returns the wr_err seen just after the edge.
   task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                           output logic e1, output logic e2);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
      cyc();
      wr_en = 1'b0; wr_strb = '0;
      e1 = we1; e2 = we2;
   endtask

   // One read request; captures LAT1 results after one edge and LAT2 results after two.
   task automatic do_read(input logic [63:0] a, output logic v1, output logic e1,
                          output logic [63:0] d1, output logic v2, output logic e2,
                          output logic [63:0] d2, output logic early2);
      rd_en = 1'b1; rd_addr = a;
      cyc();
      rd_en = 1'b0;
      v1 = rv1; e1 = re1; d1 = rd1; early2 = rv2;
      cyc();
      v2 = rv2; e2 = re2; d2 = rd2;
   endtask

   // Waits for ready, returning how many edges it took (bounded).
   task automatic wait_ready(output int n);
      n = 0;
      while (!rdy1 && n < 40) begin
         cyc();
         n++;
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      cyc(); cyc();
      checks++; if ({rdy1, rdy2, rv1, rv2, re1, re2, we1, we2} !== 8'h00) begin
         errors++; $display("FAIL reset_flags got %b want 00000000", {rdy1, rdy2, rv1, rv2, re1, re2, we1, we2}); end
      checks++; if (rd1 !== 64'h0 || rd2 !== 64'h0) begin
         errors++; $display("FAIL reset_data got %h/%h want 0", rd1, rd2); end
      rst = 1'b0;
      wait_ready(n);
      checks++; if (n != 16 || rdy2 !== 1'b1) begin
         errors++; $display("FAIL init_len got %0d cycles rdy2=%b want 16 rdy2=1", n, rdy2); end
   endtask

   task automatic test_clear();
      logic v1, e1, v2, e2, ea; logic [63:0] d1, d2;
      do_read(64'h8000_0040, v1, e1, d1, v2, e2, d2, ea);
      checks++; if (v1 !== 1'b1 || e1 !== 1'b0 || d1 !== 64'h0) begin
         errors++; $display("FAIL clear_l1 got v=%b e=%b d=%h want 1 0 0", v1, e1, d1); end
      checks++; if (ea !== 1'b0 || v2 !== 1'b1 || e2 !== 1'b0 || d2 !== 64'h0) begin
         errors++; $display("FAIL clear_l2 got early=%b v=%b e=%b d=%h want 0 1 0 0", ea, v2, e2, d2); end
   endtask

   task automatic test_strobe();
      logic v1, e1, v2, e2, ea, w1, w2; logic [63:0] d1, d2;
      do_write(64'h8000_0008, 64'h1122334455667788, 8'hFF, w1, w2);
      do_write(64'h8000_0008, 64'hAAAAAAAAAAAAAAAA, 8'h0F, w1, w2);
      checks++; if (w1 !== 1'b0 || w2 !== 1'b0) begin
         errors++; $display("FAIL strobe_wr_err got %b/%b want 0", w1, w2); end
      do_read(64'h8000_0008, v1, e1, d1, v2, e2, d2, ea);
      checks++; if (v1 !== 1'b1 || d1 !== 64'h11223344AAAAAAAA) begin
         errors++; $display("FAIL strobe_l1 got v=%b d=%h want 1 11223344aaaaaaaa", v1, d1); end
      checks++; if (ea !== 1'b0 || v2 !== 1'b1 || d2 !== 64'h11223344AAAAAAAA) begin
         errors++; $display("FAIL strobe_l2 got early=%b v=%b d=%h want 0 1 11223344aaaaaaaa", ea, v2, d2); end
      cyc();
      checks++; if (rv1 !== 1'b0 || rv2 !== 1'b0 || rd1 !== 64'h11223344AAAAAAAA || rd2 !== 64'h11223344AAAAAAAA) begin
         errors++; $display("FAIL hold got v=%b/%b d=%h/%h want 0/0 11223344aaaaaaaa", rv1, rv2, rd1, rd2); end
   endtask

   task automatic test_collision();
      logic v1, e1, v2, e2, ea; logic [63:0] d1, d2;
      rd_en = 1'b1; rd_addr = 64'h8000_0010;
      wr_en = 1'b1; wr_addr = 64'h8000_0010; wr_data = '1; wr_strb = 8'hF0;
      cyc();
      rd_en = 1'b0; wr_en = 1'b0; wr_strb = '0;
      checks++; if (rv1 !== 1'b1 || rd1 !== 64'hFFFFFFFF00000000) begin
         errors++; $display("FAIL coll_l1 got v=%b d=%h want 1 ffffffff00000000", rv1, rd1); end
      cyc();
      checks++; if (rv2 !== 1'b1 || rd2 !== 64'hFFFFFFFF00000000) begin
         errors++; $display("FAIL coll_l2 got v=%b d=%h want 1 ffffffff00000000", rv2, rd2); end
      do_read(64'h8000_0010, v1, e1, d1, v2, e2, d2, ea);
      checks++; if (d1 !== 64'hFFFFFFFF00000000 || d2 !== 64'hFFFFFFFF00000000) begin
         errors++; $display("FAIL coll_stored got %h/%h want ffffffff00000000", d1, d2); end
   endtask

   task automatic test_range();
      logic v1, e1, v2, e2, ea, w1, w2; logic [63:0] d1, d2;
      do_write(64'h8000_0080, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, w1, w2);
      checks++; if (w1 !== 1'b1 || w2 !== 1'b1) begin
         errors++; $display("FAIL wr_err_pulse got %b/%b want 1/1", w1, w2); end
      cyc();
      checks++; if (we1 !== 1'b0 || we2 !== 1'b0) begin
         errors++; $display("FAIL wr_err_clear got %b/%b want 0/0", we1, we2); end
      do_read(64'h8000_0000, v1, e1, d1, v2, e2, d2, ea);
      checks++; if (d1 !== 64'h0 || d2 !== 64'h0 || e1 !== 1'b0 || e2 !== 1'b0) begin
         errors++; $display("FAIL word0_intact got %h/%h err=%b/%b want 0", d1, d2, e1, e2); end
      do_read(64'h8000_0008, v1, e1, d1, v2, e2, d2, ea);
      do_read(64'h7FFF_FFF8, v1, e1, d1, v2, e2, d2, ea);
      checks++; if (v1 !== 1'b1 || e1 !== 1'b1 || d1 !== 64'h0) begin
         errors++; $display("FAIL rd_err_l1 got v=%b e=%b d=%h want 1 1 0", v1, e1, d1); end
      checks++; if (ea !== 1'b0 || v2 !== 1'b1 || e2 !== 1'b1 || d2 !== 64'h0) begin
         errors++; $display("FAIL rd_err_l2 got early=%b v=%b e=%b d=%h want 0 1 1 0", ea, v2, e2, d2); end
      cyc();
      checks++; if (re1 !== 1'b0 || re2 !== 1'b0) begin
         errors++; $display("FAIL rd_err_clear got %b/%b want 0/0", re1, re2); end
   endtask

   task automatic test_back_to_back();
      int bad_w = 0;
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_addr = 64'h8000_0000 + 64'(i * 8); wr_data = pat(i); wr_strb = 8'hFF;
         cyc();
         if (we1 !== 1'b0 || we2 !== 1'b0) bad_w++;
      end
      wr_en = 1'b0; wr_strb = '0;
      checks++; if (bad_w != 0) begin
         errors++; $display("FAIL b2b_wr_err got %0d error pulses want 0", bad_w); end
      for (int i = 0; i < 18; i++) begin
         rd_en = (i < 16); rd_addr = 64'h8000_0000 + 64'(i * 8);
         cyc();
         checks++;
         if (i < 16) begin
            if (rv1 !== 1'b1 || rd1 !== pat(i)) begin
               errors++; $display("FAIL b2b_l1[%0d] got v=%b d=%h want 1 %h", i, rv1, rd1, pat(i)); end
         end else if (rv1 !== 1'b0) begin
            errors++; $display("FAIL b2b_l1_tail[%0d] got v=%b want 0", i, rv1);
         end
         checks++;
         if (i >= 1 && i <= 16) begin
            if (rv2 !== 1'b1 || rd2 !== pat(i - 1)) begin
               errors++; $display("FAIL b2b_l2[%0d] got v=%b d=%h want 1 %h", i, rv2, rd2, pat(i - 1)); end
         end else if (rv2 !== 1'b0) begin
            errors++; $display("FAIL b2b_l2_edge[%0d] got v=%b want 0", i, rv2);
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_late_write();
      logic v1, e1, v2, e2, ea; logic [63:0] d1, d2;
      rd_en = 1'b1; rd_addr = 64'h8000_0018;
      cyc();
      rd_en = 1'b0;
      checks++; if (rv1 !== 1'b1 || rd1 !== pat(3)) begin
         errors++; $display("FAIL late_l1 got v=%b d=%h want 1 %h", rv1, rd1, pat(3)); end
      wr_en = 1'b1; wr_addr = 64'h8000_0018; wr_data = 64'h0123_4567_89AB_CDEF; wr_strb = 8'hFF;
      cyc();
      wr_en = 1'b0; wr_strb = '0;
      checks++; if (rv2 !== 1'b1 || rd2 !== pat(3)) begin
         errors++; $display("FAIL late_l2_old got v=%b d=%h want 1 %h", rv2, rd2, pat(3)); end
      do_read(64'h8000_0018, v1, e1, d1, v2, e2, d2, ea);
      checks++; if (d1 !== 64'h0123_4567_89AB_CDEF || d2 !== 64'h0123_4567_89AB_CDEF) begin
         errors++; $display("FAIL late_new got %h/%h want 0123456789abcdef", d1, d2); end
   endtask

   task automatic test_rst_mid();
      logic v1, e1, v2, e2, ea; logic [63:0] d1, d2;
      int n, bad;
      rd_en = 1'b1; rd_addr = 64'h8000_0028;
      cyc();
      rd_en = 1'b0; rst = 1'b1;
      cyc();
      checks++; if (rv1 !== 1'b0 || rv2 !== 1'b0 || rdy1 !== 1'b0 || rdy2 !== 1'b0) begin
         errors++; $display("FAIL rst_flush got v=%b/%b rdy=%b/%b want 0", rv1, rv2, rdy1, rdy2); end
      rst = 1'b0;
      rd_en = 1'b1; rd_addr = 64'h8000_0000; wr_en = 1'b1; wr_addr = 64'h8000_0080;
      wr_data = '1; wr_strb = 8'hFF;
      bad = 0;
      for (int i = 0; i < 7; i++) begin
         cyc();
         if (rv1 | rv2 | re1 | re2 | we1 | we2 | rdy1 | rdy2) bad++;
      end
      checks++; if (bad != 0) begin
         errors++; $display("FAIL init_ignore got %0d active cycles want 0", bad); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bad = 0;
      n = 0;
      while (!rdy1 && n < 40) begin
         cyc();
         n++;
         if (rv1 | rv2 | we1 | we2) bad++;
      end
      rd_en = 1'b0; wr_en = 1'b0; wr_strb = '0;
      checks++; if (n != 16 || bad != 0) begin
         errors++; $display("FAIL init_restart got %0d cycles %0d stray pulses want 16 0", n, bad); end
      do_read(64'h8000_0028, v1, e1, d1, v2, e2, d2, ea);
      checks++; if (v1 !== 1'b1 || d1 !== 64'h0 || v2 !== 1'b1 || d2 !== 64'h0) begin
         errors++; $display("FAIL reclear got v=%b/%b d=%h/%h want 1/1 0", v1, v2, d1, d2); end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_strobe();
      test_collision();
      test_range();
      test_back_to_back();
      test_late_write();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
